approx_mul_arbiter: RTL and testbench

APPROX_MUL_ARBITER -- requirements
Module: approx_mul_arbiter

---
 rtl/approx_mul_arbiter.sv | 127 ++++++++++++
 tb/tb_approx_mul_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter
//   Shares one external combinational approximate log multiplier between
//   NREQ requesters. A round-robin arbiter grants one requester per cycle into
//   a two-stage pipeline: S1 holds the operands that drive the multiplier, and
//   S2 captures the product together with the id of the requester that owns it.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester operand valid            [NREQ]
//   req_ready  per-requester accept, one-hot or zero  [NREQ]
//   req_x      packed X operands, requester i at [i*SZ +: SZ]
//   req_y      packed Y operands, same packing
//   mul_x      X operand to the multiplier (registered S1 operand)
//   mul_y      Y operand to the multiplier (registered S1 operand)
//   mul_m      product returned by the multiplier     [2*SZ]
//   rsp_valid  result valid
//   rsp_ready  consumer accepts the result
//   rsp_m      product                                [2*SZ]
//   rsp_id     owning requester index                 [IDW]
//   op_count   saturating count of delivered results  [16]

module approx_mul_arbiter #(
    parameter  int NREQ = 4,
    parameter  int SZ   = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*SZ-1:0]   req_x,
    input  logic [NREQ*SZ-1:0]   req_y,
    output logic [SZ-1:0]        mul_x,
    output logic [SZ-1:0]        mul_y,
    input  logic [2*SZ-1:0]      mul_m,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*SZ-1:0]      rsp_m,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          op_count
);

    logic           s1_valid;
    logic [IDW-1:0] s1_id;
    logic           s1_zero;
    logic [IDW-1:0] ptr;

    logic           adv1;
    logic           adv2;
    logic           found;
    logic [IDW-1:0] gnt;
    logic           hs;
    logic [SZ-1:0]  sel_x;
    logic [SZ-1:0]  sel_y;
    int             idx;

    // S2 (rsp_valid) drains or is empty -> S2 may load; S1 may load whenever
    // it is empty or moving into S2, which gives back-to-back issue.
    assign adv2 = !rsp_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    // Round-robin search starting at ptr, wrapping mod NREQ.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx[IDW-1:0];
            end
        end
    end

    assign hs    = !rst && adv1 && found;
    assign sel_x = req_x[int'(gnt)*SZ +: SZ];
    assign sel_y = req_y[int'(gnt)*SZ +: SZ];

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_zero   <= 1'b0;
            mul_x     <= '0;
            mul_y     <= '0;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_m     <= '0;
            rsp_id    <= '0;
            op_count  <= '0;
        end else begin
            if (rsp_valid && rsp_ready && (op_count != 16'hFFFF)) begin
                op_count <= op_count + 16'd1;
            end

            if (adv2) begin
                rsp_valid <= s1_valid;
                if (s1_valid) begin
                    // Log multipliers cannot represent zero; force an exact 0.
                    rsp_m  <= s1_zero ? '0 : mul_m;
                    rsp_id <= s1_id;
                end
            end

            if (adv1) begin
                s1_valid <= hs;
                if (hs) begin
                    mul_x   <= sel_x;
                    mul_y   <= sel_y;
                    s1_id   <= gnt;
                    s1_zero <= (sel_x == '0) || (sel_y == '0);
                    ptr     <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// tb_approx_mul_arbiter
//   Randomised and directed stimulus against a transaction-level reference
//   model of the arbiter and its two pipeline slots. A mock multiplier
//   returns mul_x*mul_y, or a forced constant.

module tb_approx_mul_arbiter;

    localparam int NREQ = 4;
    localparam int SZ   = 8;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*SZ-1:0]  req_x;
    logic [NREQ*SZ-1:0]  req_y;
    logic [SZ-1:0]       mul_x;
    logic [SZ-1:0]       mul_y;
    logic [2*SZ-1:0]     mul_m;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [2*SZ-1:0]     rsp_m;
    logic [1:0]          rsp_id;
    logic [15:0]         op_count;

    logic                force_m;
    logic [15:0]         force_val;

    assign mul_m = force_m ? force_val : ({8'b0, mul_x} * {8'b0, mul_y});

    approx_mul_arbiter #(.NREQ(NREQ), .SZ(SZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_m     (mul_m),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_m     (rsp_m),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one operand slot feeding the multiplier, one result slot.
    int          m_ptr = 0;
    bit          m_s1v = 0;
    logic [7:0]  m_s1x = 0;
    logic [7:0]  m_s1y = 0;
    int          m_s1id = 0;
    bit          m_s2v = 0;
    logic [15:0] m_s2m = 0;
    int          m_s2id = 0;
    int          m_cnt = 0;

    function automatic logic [15:0] product(input logic [7:0] x, input logic [7:0] y);
        if (x == 0 || y == 0) return 16'h0;
        if (force_m) return force_val;
        return 16'(x) * 16'(y);
    endfunction

    task automatic step(input logic [3:0] rv, input logic [31:0] rx, input logic [31:0] ry,
                        input logic rr, input logic r, input bit chk_on,
                        output logic [3:0] seen);
        bit         a1, a2, fnd;
        int         g, i;
        logic [3:0] exp_rdy;
        req_valid = rv;
        req_x     = rx;
        req_y     = ry;
        rsp_ready = rr;
        rst       = r;
        a2  = !m_s2v || rr;
        a1  = !m_s1v || a2;
        fnd = 0;
        g   = 0;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (!fnd && rv[i]) begin
                fnd = 1;
                g   = i;
            end
        end
        exp_rdy = (!r && a1 && fnd) ? 4'(1 << g) : 4'b0;
        #1;
        seen = req_ready;
        if (chk_on) begin
            check("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_s2v});
            check("rsp_m", {16'b0, rsp_m}, {16'b0, m_s2m});
            check("rsp_id", {30'b0, rsp_id}, m_s2id);
            check("mul_x", {24'b0, mul_x}, {24'b0, m_s1x});
            check("mul_y", {24'b0, mul_y}, {24'b0, m_s1y});
            check("op_count", {16'b0, op_count}, m_cnt);
        end
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_s1v = 0; m_s1x = 0; m_s1y = 0; m_s1id = 0;
            m_s2v = 0; m_s2m = 0; m_s2id = 0; m_cnt = 0;
        end else begin
            if (m_s2v && rr && m_cnt != 16'hFFFF) m_cnt++;
            if (a2) begin
                if (m_s1v) begin
                    m_s2m  = product(m_s1x, m_s1y);
                    m_s2id = m_s1id;
                end
                m_s2v = m_s1v;
            end
            if (a1) begin
                m_s1v = fnd;
                if (fnd) begin
                    m_s1x  = rx[g*8 +: 8];
                    m_s1y  = ry[g*8 +: 8];
                    m_s1id = g;
                    m_ptr  = (g + 1) % NREQ;
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_ops();
        logic [31:0] v;
        for (int b = 0; b < 4; b++) begin
            v[b*8 +: 8] = ($urandom_range(0, 9) == 0) ? 8'h0 : 8'($urandom);
        end
        return v;
    endfunction

    logic [3:0] seen;
    int         hs_cnt;

    initial begin
        rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
        force_m = 1'b0; force_val = 16'h0;
        @(negedge clk);

        // Reset state, with requests pending that must not be accepted.
        step(4'hF, rnd_ops(), rnd_ops(), 1, 1, 0, seen);
        step(4'hF, rnd_ops(), rnd_ops(), 1, 1, 1, seen);

        // Single request from requester 2: 12*10.
        step(4'b0100, 32'h000C_0000, 32'h000A_0000, 1, 0, 1, seen);
        check("sr_rdy", {28'b0, seen}, 32'h4);
        step(4'b0000, rnd_ops(), rnd_ops(), 1, 0, 1, seen);
        check("sr_valid", {31'b0, rsp_valid}, 1);
        check("sr_m", {16'b0, rsp_m}, 120);
        check("sr_id", {30'b0, rsp_id}, 2);
        step(4'b0000, rnd_ops(), rnd_ops(), 1, 0, 1, seen);
        check("sr_cnt", {16'b0, op_count}, 1);

        // Round robin with every requester asking.
        step(4'h0, 0, 0, 1, 1, 1, seen);
        for (int n = 0; n < 8; n++) begin
            step(4'hF, rnd_ops(), rnd_ops(), 1, 0, 1, seen);
            check("rr_gnt", {28'b0, seen}, 32'(1 << (n % 4)));
        end
        for (int n = 0; n < 3; n++) step(4'h0, 0, 0, 1, 0, 1, seen);

        // Backpressure: only two operations fit while the consumer stalls.
        step(4'h0, 0, 0, 1, 1, 1, seen);
        hs_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            step(4'b0001, rnd_ops(), rnd_ops(), 0, 0, 1, seen);
            if (seen != 0) hs_cnt++;
        end
        check("bp_hs", hs_cnt, 2);
        for (int n = 0; n < 4; n++) step(4'h0, 0, 0, 1, 0, 1, seen);
        check("bp_cnt", {16'b0, op_count}, 2);

        // Zero operand bypasses the forced multiplier output.
        force_m = 1'b1; force_val = 16'h1234;
        step(4'b0001, 32'h0000_0000, 32'h0000_00C8, 1, 0, 1, seen);
        step(4'h0, 0, 0, 1, 0, 1, seen);
        check("zb_valid", {31'b0, rsp_valid}, 1);
        check("zb_m", {16'b0, rsp_m}, 0);
        step(4'h0, 0, 0, 1, 0, 1, seen);
        force_m = 1'b0;

        // Reset with both stages full, then a clean request.
        step(4'hF, rnd_ops(), rnd_ops(), 0, 0, 1, seen);
        step(4'hF, rnd_ops(), rnd_ops(), 0, 0, 1, seen);
        step(4'hF, rnd_ops(), rnd_ops(), 0, 1, 1, seen);
        check("rst_valid", {31'b0, rsp_valid}, 0);
        check("rst_cnt", {16'b0, op_count}, 0);
        step(4'b1000, 32'h0700_0000, 32'h0900_0000, 1, 0, 1, seen);
        check("rst_gnt", {28'b0, seen}, 32'h8);
        step(4'h0, 0, 0, 1, 0, 1, seen);
        check("rst_m", {16'b0, rsp_m}, 63);
        step(4'h0, 0, 0, 1, 0, 1, seen);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            force_m = ($urandom_range(0, 9) == 0);
            force_val = 16'($urandom);
            step(4'($urandom), rnd_ops(), rnd_ops(), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) == 0), 1, seen);
        end
        force_m = 1'b0;

        // Saturation of the delivered-results counter.
        step(4'h0, 0, 0, 1, 1, 1, seen);
        for (int n = 0; n < 65540; n++) begin
            step(4'hF, rnd_ops(), rnd_ops(), 1, 0, 0, seen);
        end
        check("sat_cnt", {16'b0, op_count}, 32'hFFFF);
        step(4'hF, rnd_ops(), rnd_ops(), 1, 0, 1, seen);
        check("sat_hold", {16'b0, op_count}, 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
